toggle_burst_sched: RTL and testbench
=====================================

TOGGLE_BURST_SCHED -- requirements
Module: toggle_burst_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, 2..8.
REQ-002 Parameter CW, default 8: toggle-count width.
REQ-003 clk  input  1  clock; sig1 logic on rising edge, sig2 logic on falling edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  NREQ  per-requester burst request, level; held until matching done.
REQ-006 len  input  NREQ*CW  per-requester toggle count; slice i = len[i*CW +: CW].
REQ-007 gnt  output  NREQ  one-hot grant, registered.
REQ-008 owner  output  $clog2(NREQ)  index of current grantee; valid while busy.
REQ-009 busy  output  1  high in RUN and DONE states.
REQ-010 done  output  1  one-cycle pulse at end of each granted burst.
REQ-011 sig1  output  1  burst waveform, rising-edge domain.
REQ-012 sig2  output  1  burst waveform, falling-edge domain, half a cycle behind sig1.

Function
REQ-013 FSM states IDLE, RUN, DONE; all state, gnt, owner, busy, done, sig1 update on rising edge only.
REQ-014 IDLE, any req high at rising edge: select winner, gnt[winner]=1, owner=winner, cnt=len slice of winner, go RUN.
REQ-015 Arbitration round-robin: search starts at (last_owner+1) mod NREQ; after reset, requester 0 has highest priority.
REQ-016 last_owner updates only when a grant is issued.
REQ-017 RUN, cnt!=0: per rising edge, sig1 inverts, cnt decrements by 1, tog_en=1.
REQ-018 RUN, cnt==0 (including len=0 at grant): tog_en=0, go DONE; no sig1 edge that cycle.
REQ-019 DONE: done=1 for exactly one cycle, gnt cleared, go IDLE; new grant is earliest at the following rising edge.
REQ-020 Burst of length N gives exactly N sig1 edges and N sig2 edges; grant to done = N+2 cycles.
REQ-021 sig2 inverts on falling edge only when registered tog_en is high; sig2 has no other edges.
REQ-022 sig1 and sig2 keep their level between bursts; no restoring edge.
REQ-023 len sampled only at grant; later len changes do not affect the active burst.
REQ-024 req deassert during RUN is ignored; burst runs to completion.
REQ-025 Max len (2^CW-1) supported; cnt never wraps below 0.
REQ-026 Requests arriving in RUN/DONE wait; no request is lost while held.

Reset
REQ-027 Rising edge with rst=1: state=IDLE, gnt=0, owner=0, busy=0, done=0, cnt=0, tog_en=0, sig1=0, last_owner=NREQ-1.
REQ-028 Falling edge with rst=1: sig2=1.
REQ-029 rst mid-burst aborts immediately; no done pulse for the aborted burst; requests re-arbitrated from requester 0 after release.

Verification
REQ-030 Single req[0], len=10 -> gnt=0001 next edge; 10 sig1 edges (ends 0), 10 sig2 edges (ends 1); done 12 cycles after grant.
REQ-031 req[0..3] all held, len=3 each -> grant order 0,1,2,3,0; one DONE cycle between bursts; each done pulse one cycle.
REQ-032 req[2], len=0 -> gnt=0100 for one RUN cycle, done pulse, zero edges on sig1/sig2.
REQ-033 len changed to 1 and req dropped mid-burst of len=5 -> still 5 edges per signal, then done.
REQ-034 rst asserted at 4th toggle of len=10 burst -> sig1=0, sig2=1, gnt=0, no done; after release req[1],req[0] held -> gnt=0001 first.
REQ-035 Check every sig2 edge follows a sig1 edge by half a period; sig2 never toggles when tog_en=0.

Source files
------------

// File: rtl/toggle_burst_sched.sv
// Round-robin burst scheduler: the granted requester receives a burst of N toggles
// on sig1 (rising-edge domain), mirrored half a cycle later on sig2 (falling-edge domain).
module toggle_burst_sched #(
  parameter int NREQ = 4,
  parameter int CW   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*CW-1:0]        len,
  output logic [NREQ-1:0]           gnt,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      busy,
  output logic                      done,
  output logic                      sig1,
  output logic                      sig2
);

  localparam int OW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [OW-1:0]   r_owner;
  logic [OW-1:0]   r_last;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic            r_tog_en;
  logic            r_sig1;
  logic            r_sig2;

  logic [CW-1:0]   w_len [NREQ];
  logic [OW-1:0]   w_win;
  logic            w_any;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_len
      assign w_len[gi] = len[gi*CW +: CW];
    end
  endgenerate

  // Round-robin search beginning one past the previous grantee.
  always_comb begin : arb
    logic [OW:0] idx;
    logic        found;
    idx   = '0;
    found = 1'b0;
    w_win = '0;
    w_any = |req;
    for (int k = 1; k <= NREQ; k++) begin
      idx = {1'b0, r_last} + (OW+1)'(k);
      if (idx >= (OW+1)'(NREQ)) idx = idx - (OW+1)'(NREQ);
      if (!found && req[idx[OW-1:0]]) begin
        found = 1'b1;
        w_win = idx[OW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_owner  <= '0;
      r_last   <= OW'(NREQ-1);
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_tog_en <= 1'b0;
      r_sig1   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
            r_owner <= w_win;
            r_last  <= w_win;
            r_cnt   <= w_len[w_win];
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_cnt != '0) begin
            r_sig1   <= ~r_sig1;
            r_cnt    <= r_cnt - 1'b1;
            r_tog_en <= 1'b1;
          end else begin
            r_tog_en <= 1'b0;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Falling-edge follower: each registered toggle enable produces one sig2 edge.
  always_ff @(negedge clk) begin
    if (rst) r_sig2 <= 1'b1;
    else if (r_tog_en) r_sig2 <= ~r_sig2;
  end

  assign gnt   = r_gnt;
  assign owner = r_owner;
  assign busy  = r_busy;
  assign done  = r_done;
  assign sig1  = r_sig1;
  assign sig2  = r_sig2;

endmodule

// File: tb/tb_toggle_burst_sched.sv
// Directed and randomized bursts against a round-robin/burst-count reference model.
module tb_toggle_burst_sched;

  localparam int NREQ = 4;
  localparam int CW   = 8;
  localparam int OW   = $clog2(NREQ);

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ*CW-1:0]  len;
  logic [NREQ-1:0]     gnt;
  logic [OW-1:0]       owner;
  logic                busy;
  logic                done;
  logic                sig1;
  logic                sig2;

  int  checks = 0;
  int  errors = 0;
  int  e1 = 0;
  int  e2 = 0;
  time t1 = 0;
  bit  mon_en = 0;
  int  m_last;
  logic m_sig1, m_sig2;

  toggle_burst_sched #(.NREQ(NREQ), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .len(len), .gnt(gnt), .owner(owner),
    .busy(busy), .done(done), .sig1(sig1), .sig2(sig2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(sig1) begin
    if (mon_en) begin
      e1++;
      t1 = $time;
    end
  end

  // Every sig2 edge must trail a sig1 edge by exactly half a period.
  always @(sig2) begin
    if (mon_en && !rst) begin
      e2++;
      checks++;
      assert (($time - t1) == 5 && e2 <= e1) else begin
        errors++;
        $error("FAIL sig2_spacing: observed dt=%0t e1=%0d e2=%0d expected dt=5 e2<=e1", $time - t1, e1, e2);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] mask, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (mask[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic int len_of(input int i);
    logic [NREQ*CW-1:0] l;
    l = len;
    return int'(l[i*CW +: CW]);
  endfunction

  task automatic rand_len(input int maxv);
    for (int i = 0; i < NREQ; i++) len[i*CW +: CW] = CW'($urandom_range(0, maxv));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sig1", 32'(sig1), 0);
    chk("rst_sig2", 32'(sig2), 1);
    rst = 1'b0;
    m_last = NREQ - 1;
    m_sig1 = 1'b0;
    m_sig2 = 1'b1;
    mon_en = 1'b1;
  endtask

  // Grant happens at the next edge; burst must end with done exactly n+2 cycles later.
  task automatic do_burst(input int w, input int n, input int chg_at);
    int c, b1, b2;
    bit got;
    tick();
    chk("grant_gnt", 32'(gnt), 32'(1) << w);
    chk("grant_owner", 32'(owner), 32'(w));
    chk("grant_busy", 32'(busy), 1);
    chk("grant_done_low", 32'(done), 0);
    $display("burst: winner=%0d len=%0d chg_at=%0d", w, n, chg_at);
    m_last = w;
    b1 = e1;
    b2 = e2;
    got = 0;
    c = 0;
    while (!got && c < n + 10) begin
      if (c == chg_at) begin
        req = NREQ'($urandom);
        rand_len(12);
      end
      tick();
      c++;
      if (done) got = 1;
      else if (c < n + 2) chk("run_busy", 32'(busy), 1);
    end
    if (n % 2 == 1) begin
      m_sig1 = ~m_sig1;
      m_sig2 = ~m_sig2;
    end
    chk("done_seen", 32'(got), 1);
    chk("grant_to_done", 32'(c), 32'(n + 2));
    chk("sig1_edges", 32'(e1 - b1), 32'(n));
    chk("sig2_edges", 32'(e2 - b2), 32'(n));
    chk("done_gnt", 32'(gnt), 0);
    chk("done_busy", 32'(busy), 0);
    chk("sig1_level", 32'(sig1), 32'(m_sig1));
    chk("sig2_level", 32'(sig2), 32'(m_sig2));
  endtask

  initial begin
    int w, c;
    rst = 1'b1;
    req = '0;
    len = '0;
    do_reset();

    // Single requester, len 10
    req = 4'b0001;
    len[0 +: CW] = 8'd10;
    do_burst(rr_pick(req, m_last), 10, -1);

    // All four held, len 3 each: expect 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) len[i*CW +: CW] = 8'd3;
    for (int k = 0; k < 5; k++) begin
      w = rr_pick(req, m_last);
      chk("rr_order", 32'(w), 32'(k % NREQ));
      do_burst(w, 3, -1);
    end

    // Zero-length burst
    req = 4'b0100;
    len = '0;
    do_burst(rr_pick(req, m_last), 0, -1);

    // Mid-burst len change and req drop are ignored
    req = 4'b0010;
    len[CW +: CW] = 8'd5;
    fork
      begin
        repeat (3) @(posedge clk);
        #2;
        req = '0;
        len[CW +: CW] = 8'd1;
      end
    join_none
    do_burst(1, 5, -1);
    req = '0;
    tick();
    chk("idle_gnt", 32'(gnt), 0);
    chk("idle_done", 32'(done), 0);

    // Reset at the 4th toggle of a len-10 burst
    req = 4'b0001;
    len[0 +: CW] = 8'd10;
    tick();
    chk("abort_grant", 32'(gnt), 1);
    c = e1;
    for (int k = 0; k < 20 && (e1 - c) < 4; k++) tick();
    chk("abort_reached4", 32'(e1 - c), 4);
    rst = 1'b1;
    tick();
    chk("abort_gnt", 32'(gnt), 0);
    chk("abort_sig1", 32'(sig1), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    tick();
    chk("abort_sig2", 32'(sig2), 1);
    chk("abort_done2", 32'(done), 0);
    rst = 1'b0;
    m_last = NREQ - 1;
    m_sig1 = 1'b0;
    m_sig2 = 1'b1;
    req = 4'b0011;
    w = rr_pick(req, m_last);
    chk("abort_rearb", 32'(w), 0);
    do_burst(w, 10, -1);

    // Maximum length
    req = 4'b0001;
    len[0 +: CW] = 8'd255;
    do_burst(rr_pick(req, m_last), 255, -1);

    // Randomized requests and lengths
    for (int it = 0; it < 30; it++) begin
      req = NREQ'($urandom);
      rand_len(12);
      if (req == '0) begin
        tick();
        chk("rand_idle_gnt", 32'(gnt), 0);
        chk("rand_idle_busy", 32'(busy), 0);
      end else begin
        w = rr_pick(req, m_last);
        do_burst(w, len_of(w), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
